// File: rtl/nes_controller_reader.sv
// nes_controller_reader
//
// Polls two NES-style controllers over a shared latch/clock pair and shifts in
// both serial data lines. Each completed frame is published as a 16-bit
// active-high button word, {P1 byte, P2 byte}, with each byte ordered
// A, B, Select, Start, Up, Down, Left, Right from MSB to LSB.
//
// Ports:
//   clk              system clock
//   nrst             asynchronous active-low reset
//   enable           permits new polls to start (sampled at poll-counter wrap)
//   data_p1/data_p2  controller serial data, active-low, asynchronous to clk
//   ctrl_latch       shared controller latch, active-high
//   ctrl_clk         shared controller clock, idles high
//   controllerInputs last complete frame, active-high
//   frame_valid      one-cycle pulse when controllerInputs updates
//   busy             high whenever a frame is in progress
module nes_controller_reader #(
  parameter int unsigned HALF_CYCLES  = 4,
  parameter int unsigned LATCH_CYCLES = 8,
  parameter int unsigned POLL_PERIOD  = 200
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        data_p1,
  input  logic        data_p2,
  output logic        ctrl_latch,
  output logic        ctrl_clk,
  output logic [15:0] controllerInputs,
  output logic        frame_valid,
  output logic        busy
);

  localparam int unsigned PollW    = $clog2(POLL_PERIOD);
  localparam int unsigned PhaseMax = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);

  localparam logic [PollW-1:0]  PollLast  = PollW'(POLL_PERIOD - 1);
  localparam logic [PhaseW-1:0] LatchLast = PhaseW'(LATCH_CYCLES - 1);
  localparam logic [PhaseW-1:0] HalfLast  = PhaseW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StLow,
    StHigh,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        p1_sr_q, p1_sr_d;
  logic [7:0]        p2_sr_q, p2_sr_d;
  logic [15:0]       inputs_q, inputs_d;
  logic              latch_q, latch_d;
  logic              cclk_q, cclk_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              sync1_p1_q, sync2_p1_q;
  logic              sync1_p2_q, sync2_p2_q;
  logic              poll_wrap;

  // Two-flop synchronizers; reset high to match an idle (released) data line.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_p1_q <= 1'b1;
      sync2_p1_q <= 1'b1;
      sync1_p2_q <= 1'b1;
      sync2_p2_q <= 1'b1;
    end else begin
      sync1_p1_q <= data_p1;
      sync2_p1_q <= sync1_p1_q;
      sync1_p2_q <= data_p2;
      sync2_p2_q <= sync1_p2_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    p1_sr_d    = p1_sr_q;
    p2_sr_d    = p2_sr_q;
    poll_wrap  = (poll_cnt_q == PollLast);
    poll_cnt_d = poll_wrap ? '0 : poll_cnt_q + PollW'(1);

    case (state_q)
      StIdle: begin
        // A wrap seen while busy is simply dropped; nothing is queued.
        if (poll_wrap && enable) begin
          state_d = StLatch;
          phase_d = '0;
        end
      end
      StLatch: begin
        if (phase_q == LatchLast) begin
          state_d = StLow;
          phase_d = '0;
          bit_d   = 3'd0;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StLow: begin
        if (phase_q == HalfLast) begin
          // Sample late in the low phase so the synchronized bit has settled.
          p1_sr_d = {p1_sr_q[6:0], ~sync2_p1_q};
          p2_sr_d = {p2_sr_q[6:0], ~sync2_p2_q};
          phase_d = '0;
          state_d = (bit_q == 3'd7) ? StDone : StHigh;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StHigh: begin
        if (phase_q == HalfLast) begin
          bit_d   = bit_q + 3'd1;
          phase_d = '0;
          state_d = StLow;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        phase_d = '0;
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase

    // Outputs are registered from the next state so each takes effect in the
    // first cycle of the state that sets it.
    latch_d  = (state_d == StLatch);
    cclk_d   = (state_d != StLow);
    busy_d   = (state_d != StIdle);
    valid_d  = (state_d == StDone);
    inputs_d = (state_d == StDone) ? {p1_sr_d, p2_sr_d} : inputs_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      poll_cnt_q <= '0;
      phase_q    <= '0;
      bit_q      <= 3'd0;
      p1_sr_q    <= 8'h00;
      p2_sr_q    <= 8'h00;
      inputs_q   <= 16'h0000;
      latch_q    <= 1'b0;
      cclk_q     <= 1'b1;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      p1_sr_q    <= p1_sr_d;
      p2_sr_q    <= p2_sr_d;
      inputs_q   <= inputs_d;
      latch_q    <= latch_d;
      cclk_q     <= cclk_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign ctrl_latch       = latch_q;
  assign ctrl_clk         = cclk_q;
  assign controllerInputs = inputs_q;
  assign frame_valid      = valid_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a behavioural model of two
// NES controllers (parallel load on latch rise, shift on ctrl_clk rise).
module tb_nes_controller_reader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        enable;
  logic        data_p1;
  logic        data_p2;
  logic        ctrl_latch;
  logic        ctrl_clk;
  logic [15:0] controllerInputs;
  logic        frame_valid;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Button states, active-high, bit 7 = A ... bit 0 = Right.
  logic [7:0] btn1, btn2;
  logic [7:0] m1, m2;

  nes_controller_reader dut (
    .clk              (clk),
    .nrst             (nrst),
    .enable           (enable),
    .data_p1          (data_p1),
    .data_p2          (data_p2),
    .ctrl_latch       (ctrl_latch),
    .ctrl_clk         (ctrl_clk),
    .controllerInputs (controllerInputs),
    .frame_valid      (frame_valid),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge ctrl_latch) begin
    m1 <= ~btn1;
    m2 <= ~btn2;
  end

  always @(posedge ctrl_clk) begin
    if (ctrl_latch === 1'b0) begin
      m1 <= {m1[6:0], 1'b1};
      m2 <= {m2[6:0], 1'b1};
    end
  end

  assign data_p1 = m1[7];
  assign data_p2 = m2[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_latch(input int limit, output int ok);
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      step(1);
      if (ctrl_latch === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_fv(input int limit, output int ok);
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      step(1);
      if (frame_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Observes 80 cycles starting at the cycle ctrl_latch is first seen high.
  task automatic watch_frame(output int latch_len, output int low_pulses, output int low_min,
                             output int low_max, output int busy_len, output int fv_at,
                             output int fv_cnt);
    int run;
    run = 0;
    latch_len = 0;
    low_pulses = 0;
    low_min = 1000;
    low_max = 0;
    busy_len = 0;
    fv_at = -1;
    fv_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) step(1);
      if (ctrl_latch === 1'b1) latch_len++;
      if (busy === 1'b1) busy_len++;
      if (frame_valid === 1'b1) begin
        fv_cnt++;
        fv_at = k;
      end
      if (ctrl_clk === 1'b0) begin
        run++;
      end else if (run > 0) begin
        low_pulses++;
        if (run < low_min) low_min = run;
        if (run > low_max) low_max = run;
        run = 0;
      end
    end
  endtask

  initial begin
    int ok, rel, l0;
    int latch_len, low_pulses, low_min, low_max, busy_len, fv_at, fv_cnt;

    nrst   = 1'b1;
    enable = 1'b1;
    btn1   = 8'($urandom);
    btn2   = 8'($urandom);
    m1     = 8'($urandom);
    m2     = 8'($urandom);
    #3 nrst = 1'b0;

    // 1. Reset state with random data lines.
    step(3);
    m1 = 8'($urandom);
    m2 = 8'($urandom);
    step(2);
    chk("rst_latch", 32'(ctrl_latch), 32'h0);
    chk("rst_clk", 32'(ctrl_clk), 32'h1);
    chk("rst_inputs", 32'(controllerInputs), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // 2. P1 = A, P2 = none.
    btn1 = 8'h80;
    btn2 = 8'h00;
    nrst = 1'b1;
    rel  = cyc;
    wait_latch(300, ok);
    chk("first_latch_seen", 32'(ok), 32'h1);
    chk("first_latch_delay", 32'(cyc - rel), 32'd200);
    l0 = cyc;
    watch_frame(latch_len, low_pulses, low_min, low_max, busy_len, fv_at, fv_cnt);
    chk("f1_latch_len", 32'(latch_len), 32'd8);
    chk("f1_low_pulses", 32'(low_pulses), 32'd8);
    chk("f1_low_min", 32'(low_min), 32'd4);
    chk("f1_low_max", 32'(low_max), 32'd4);
    chk("f1_busy_len", 32'(busy_len), 32'd69);
    chk("f1_fv_at", 32'(fv_at), 32'd68);
    chk("f1_fv_cnt", 32'(fv_cnt), 32'd1);
    chk("f1_word", 32'(controllerInputs), 32'h8000);

    // 3. P1 = B+Start, P2 = Right; then P1 = all, P2 = A+B.
    btn1 = 8'h50;
    btn2 = 8'h01;
    wait_latch(250, ok);
    chk("f2_latch_seen", 32'(ok), 32'h1);
    chk("f2_period", 32'(cyc - l0), 32'd200);
    l0 = cyc;
    watch_frame(latch_len, low_pulses, low_min, low_max, busy_len, fv_at, fv_cnt);
    chk("f2_busy_len", 32'(busy_len), 32'd69);
    chk("f2_fv_at", 32'(fv_at), 32'd68);
    chk("f2_word", 32'(controllerInputs), 32'h5001);

    btn1 = 8'hFF;
    btn2 = 8'hC0;
    wait_latch(250, ok);
    chk("f3_period", 32'(cyc - l0), 32'd200);
    watch_frame(latch_len, low_pulses, low_min, low_max, busy_len, fv_at, fv_cnt);
    chk("f3_fv_cnt", 32'(fv_cnt), 32'd1);
    chk("f3_word", 32'(controllerInputs), 32'hFFC0);

    // 5. enable low across a wrap: no poll, value held.
    enable = 1'b0;
    btn1 = 8'h12;
    btn2 = 8'h34;
    wait_latch(250, ok);
    chk("dis_no_latch", 32'(ok), 32'h0);
    chk("dis_hold", 32'(controllerInputs), 32'hFFC0);

    // enable dropped during LOW of bit 3: frame completes, no later polls.
    enable = 1'b1;
    btn1 = 8'h0A;
    btn2 = 8'h24;
    wait_latch(250, ok);
    chk("drop_latch_seen", 32'(ok), 32'h1);
    step(33);
    chk("drop_in_low", 32'(ctrl_clk), 32'h0);
    enable = 1'b0;
    wait_fv(60, ok);
    chk("drop_fv_seen", 32'(ok), 32'h1);
    chk("drop_word", 32'(controllerInputs), 32'h0A24);
    wait_latch(450, ok);
    chk("drop_no_more", 32'(ok), 32'h0);

    // 6. Reset during HIGH of bit 4.
    enable = 1'b1;
    btn1 = 8'h01;
    btn2 = 8'h80;
    wait_latch(250, ok);
    chk("r6_latch_seen", 32'(ok), 32'h1);
    step(45);
    chk("r6_in_high", 32'({ctrl_clk, busy}), 32'h3);
    nrst = 1'b0;
    #1;
    chk("r6_clk", 32'(ctrl_clk), 32'h1);
    chk("r6_latch", 32'(ctrl_latch), 32'h0);
    chk("r6_inputs", 32'(controllerInputs), 32'h0);
    chk("r6_busy", 32'(busy), 32'h0);
    chk("r6_fv", 32'(frame_valid), 32'h0);
    step(3);
    nrst = 1'b1;
    rel  = cyc;
    wait_latch(300, ok);
    chk("r6_relatch_delay", 32'(cyc - rel), 32'd200);
    watch_frame(latch_len, low_pulses, low_min, low_max, busy_len, fv_at, fv_cnt);
    chk("r6_low_pulses", 32'(low_pulses), 32'd8);
    chk("r6_fv_at", 32'(fv_at), 32'd68);
    chk("r6_word", 32'(controllerInputs), 32'h0180);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
Drives the shared latch/clock lines of two NES-style game controllers and shifts in both serial data lines. Assembles the 16-bit active-high button word consumed by the controller input synchronizer and edge-detect stage. P1 occupies [15:8] and P2 occupies [7:0]; within each byte the order is A, B, Select, Start, Up, Down, Left, Right, MSB to LSB. Polls autonomously at a fixed period and flags each completed frame.

Parameters:
HALF_CYCLES, 4, clk cycles per ctrl_clk low or high phase; must be >= 4.
LATCH_CYCLES, 8, clk cycles ctrl_latch is held high per poll; must be >= 2.
POLL_PERIOD, 200, clk cycles between poll start opportunities; must exceed the frame length (LATCH_CYCLES + 15*HALF_CYCLES + 1).

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
enable  input  1  permits new polls to start
data_p1  input  1  P1 serial data, active-low (0 = pressed), asynchronous to clk
data_p2  input  1  P2 serial data, active-low, asynchronous to clk
ctrl_latch  output  1  shared controller latch, active-high
ctrl_clk  output  1  shared controller clock, idles high
controllerInputs  output  16  last complete frame, active-high, {P1 byte, P2 byte}
frame_valid  output  1  one-cycle pulse when controllerInputs updates
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset is decided: one clock domain; nrst is asynchronous and active-low.
- Reset values: ctrl_latch=0, ctrl_clk=1, controllerInputs=16'h0000, frame_valid=0, busy=0, FSM=IDLE, all counters=0, shift registers=0, sync flops=1.
- data_p1 and data_p2 each pass through a 2-FF synchronizer before use. Sampling always uses the synchronized value.
- All outputs come straight from flops. An output takes its new value in the first cycle of the state that sets it.
- A free-running poll counter counts 0..POLL_PERIOD-1 and wraps.
  - At wrap, if FSM=IDLE and enable=1, the next cycle enters LATCH.
  - If FSM is not IDLE at wrap, that tick is dropped and no poll is queued.
  - enable is sampled only at wrap. Deasserting enable mid-frame does not abort the frame.
- FSM states:
  - IDLE: ctrl_latch=0, ctrl_clk=1, busy=0.
  - LATCH: ctrl_latch=1, ctrl_clk=1, held LATCH_CYCLES cycles, then LOW with bit index i=0.
  - LOW: ctrl_latch=0, ctrl_clk=0, held HALF_CYCLES cycles.
    - On the last cycle, sample both lines: p1_sr <= {p1_sr[6:0], ~sync_p1}, and likewise p2_sr.
    - If i==7, go to DONE; otherwise go to HIGH.
  - HIGH: ctrl_clk=1, held HALF_CYCLES cycles. The controller shifts on this rising edge. Then i <= i+1 and go to LOW.
  - DONE: single cycle. controllerInputs <= {p1_sr, p2_sr}, frame_valid=1, ctrl_clk=1, then go to IDLE.
- Frame timing: 8 ctrl_clk low pulses and 7 internal rising edges per frame. The first bit (A) is present on the data lines at latch fall, so it ends up in the MSB of each byte.
- With defaults, if ctrl_latch first goes high in cycle 0, DONE (frame_valid=1) occurs in cycle 68.
- controllerInputs changes only in DONE. An aborted frame never produces a partial update.
- Reset mid-frame: all outputs return to reset values immediately. After release, the FSM waits for the next poll-counter wrap (POLL_PERIOD cycles after release).

Test Plan:
1. Reset: hold nrst=0 with random data lines -> ctrl_latch=0, ctrl_clk=1, controllerInputs=16'h0000, frame_valid=0, busy=0; no activity until POLL_PERIOD cycles after release.
2. Controller model returns P1 = A only and P2 = none -> controllerInputs=16'h8000 with a single-cycle frame_valid; ctrl_latch high for exactly 8 cycles; exactly 8 ctrl_clk low pulses, each 4 cycles wide.
3. P1 = B+Start, P2 = Right -> controllerInputs=16'h5001. Then P1 = all buttons, P2 = A+B -> next frame shows 16'hFFC0.
4. Timing check: frame_valid occurs exactly 68 cycles after ctrl_latch rises; consecutive ctrl_latch rising edges are exactly 200 cycles apart; busy high for exactly 69 cycles per frame.
5. enable=0 at wrap -> no latch pulse and controllerInputs holds its value. enable dropped during LOW of bit 3 -> that frame still completes and updates, and no further polls start.
6. nrst asserted during HIGH of bit 4 -> outputs reset in the same cycle (ctrl_clk=1, controllerInputs=0). After release, the first latch occurs 200 cycles later and the frame decodes correctly.
